// File: rtl/sda_kernel_args_pkg.sv
// Shared constants for the kernel control / argument register block:
// control-register word offsets, CTRL bit positions and the FSM encoding.
package sda_kernel_args_pkg;

    // Word offsets relative to CtrlAddrBase
    localparam int CTRL_OFS = 0;
    localparam int IER_OFS  = 1;
    localparam int ISR_OFS  = 2;

    // CTRL register bit positions
    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_DONE_BIT  = 1;
    localparam int CTRL_IDLE_BIT  = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } kstate_e;

endpackage

// File: rtl/sda_reg_slave_edge.sv
// Register-bus slave front end: detects the rising edge of the level request,
// produces a one-cycle acknowledge and zero-gates read data outside the ack.
module sda_reg_slave_edge (
    input  logic        clk,
    input  logic        srst,
    input  logic        reg_req,
    input  logic        reg_write_en,
    input  logic [31:0] rdata_in,
    output logic        req_edge,
    output logic        reg_ack,
    output logic [31:0] reg_rdata
);

    logic        req_q;
    logic        ack_q;
    logic        ack_d;
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    assign req_edge  = reg_req & ~req_q;
    assign reg_ack   = ack_q;
    assign reg_rdata = rdata_q;

    // Next-state for acknowledge and captured read data
    always_comb begin
        ack_d   = req_edge;
        rdata_d = 32'h0000_0000;
        if (req_edge && !reg_write_en) begin
            rdata_d = rdata_in;
        end else begin
            rdata_d = 32'h0000_0000;
        end
    end

    // Request history, ack pulse and read data registers
    always_ff @(posedge clk) begin
        if (srst) begin
            req_q   <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= 32'h0000_0000;
        end else begin
            req_q   <= reg_req;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: rtl/sda_kernel_ctrl_args.sv
// Kernel control and argument register block: CTRL start/done/idle FSM,
// write-protected argument words, optional interrupt (macro KERNEL_IRQ_EN
// adds IER/ISR registers and a registered irq output).
module sda_kernel_ctrl_args
    import sda_kernel_args_pkg::*;
#(
    parameter int RegAddrWidth  = 12,
    parameter int CtrlAddrBase  = 0,
    parameter int ParamAddrBase = 64,
    parameter int NumArgWords   = 16
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      regReq,
    output logic                      regAck,
    input  logic                      regWriteEn,
    input  logic [RegAddrWidth-1:0]   regAddr,
    input  logic [31:0]               regWData,
    input  logic [3:0]                regWStrb,
    output logic [31:0]               regRData,
    output logic [NumArgWords*32-1:0] argData,
    output logic                      kernelGo,
    input  logic                      kernelDone,
    output logic                      irq
);

    localparam logic [RegAddrWidth-1:0] CTRL_ADDR  = RegAddrWidth'(CtrlAddrBase + CTRL_OFS);
    localparam logic [RegAddrWidth-1:0] PARAM_ADDR = RegAddrWidth'(ParamAddrBase);
    localparam logic [RegAddrWidth:0]   NUM_ARGS   = (RegAddrWidth + 1)'(NumArgWords);

    logic                    req_edge_s;
    logic                    wr_s;
    logic                    rd_s;
    logic                    ctrl_hit_s;
    logic                    arg_hit_s;
    logic [RegAddrWidth-1:0] arg_off_s;
    logic                    start_s;
    logic                    done_evt_s;
    logic [31:0]             rd_mux_s;
    logic [31:0]             ctrl_val_s;

    kstate_e     state_q, state_d;
    logic        done_q, done_d;
    logic        go_q, go_d;
    logic [31:0] arg_q [NumArgWords];
    logic [31:0] arg_d [NumArgWords];

    sda_reg_slave_edge u_edge (
        .clk          (clk),
        .srst         (srst),
        .reg_req      (regReq),
        .reg_write_en (regWriteEn),
        .rdata_in     (rd_mux_s),
        .req_edge     (req_edge_s),
        .reg_ack      (regAck),
        .reg_rdata    (regRData)
    );

    // Address decode and event qualification for the current bus edge
    always_comb begin
        wr_s       = req_edge_s & regWriteEn;
        rd_s       = req_edge_s & ~regWriteEn;
        ctrl_hit_s = (regAddr == CTRL_ADDR);
        arg_off_s  = regAddr - PARAM_ADDR;
        arg_hit_s  = (regAddr >= PARAM_ADDR) && ({1'b0, arg_off_s} < NUM_ARGS);
        start_s    = wr_s & ctrl_hit_s & regWStrb[0] & regWData[CTRL_START_BIT]
                     & (state_q == ST_IDLE);
        done_evt_s = kernelDone & (state_q == ST_RUN);
        ctrl_val_s = 32'h0000_0000;
        ctrl_val_s[CTRL_START_BIT] = (state_q == ST_RUN);
        ctrl_val_s[CTRL_DONE_BIT]  = done_q;
        ctrl_val_s[CTRL_IDLE_BIT]  = (state_q == ST_IDLE);
    end

    // Kernel FSM: launch on start write in IDLE, return on kernelDone
    always_comb begin
        state_d = state_q;
        go_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = ST_RUN;
                    go_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (kernelDone) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky DONE: completion beats a coincident read-clear
    always_comb begin
        done_d = done_q;
        if (done_evt_s) begin
            done_d = 1'b1;
        end else if (start_s || (rd_s && ctrl_hit_s)) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end
    end

    // Argument byte writes, accepted only while the kernel is idle
    always_comb begin
        for (int i = 0; i < NumArgWords; i++) begin
            arg_d[i] = arg_q[i];
            for (int b = 0; b < 4; b++) begin
                if (wr_s && arg_hit_s && (state_q == ST_IDLE) &&
                    (arg_off_s == RegAddrWidth'(i)) && regWStrb[b]) begin
                    arg_d[i][8*b +: 8] = regWData[8*b +: 8];
                end else begin
                    arg_d[i][8*b +: 8] = arg_q[i][8*b +: 8];
                end
            end
        end
    end

    // Flatten argument words onto the datapath bus
    always_comb begin
        argData = '0;
        for (int i = 0; i < NumArgWords; i++) begin
            argData[32*i +: 32] = arg_q[i];
        end
    end

`ifdef KERNEL_IRQ_EN
    localparam logic [RegAddrWidth-1:0] IER_ADDR = RegAddrWidth'(CtrlAddrBase + IER_OFS);
    localparam logic [RegAddrWidth-1:0] ISR_ADDR = RegAddrWidth'(CtrlAddrBase + ISR_OFS);

    logic ier_q, ier_d;
    logic isr_q, isr_d;
    logic irq_q, irq_d;

    // Interrupt enable/status: ISR set wins over write-1-to-clear
    always_comb begin
        ier_d = ier_q;
        isr_d = isr_q;
        irq_d = ier_q & isr_q;
        if (wr_s && (regAddr == IER_ADDR) && regWStrb[0]) begin
            ier_d = regWData[0];
        end else begin
            ier_d = ier_q;
        end
        if (done_evt_s) begin
            isr_d = 1'b1;
        end else if (wr_s && (regAddr == ISR_ADDR) && regWStrb[0] && regWData[0]) begin
            isr_d = 1'b0;
        end else begin
            isr_d = isr_q;
        end
    end

    // Interrupt registers
    always_ff @(posedge clk) begin
        if (srst) begin
            ier_q <= 1'b0;
            isr_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ier_q <= ier_d;
            isr_q <= isr_d;
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;

    // Read data mux including interrupt registers
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        if (ctrl_hit_s) begin
            rd_mux_s = ctrl_val_s;
        end else if (regAddr == IER_ADDR) begin
            rd_mux_s = {31'h0000_0000, ier_q};
        end else if (regAddr == ISR_ADDR) begin
            rd_mux_s = {31'h0000_0000, isr_q};
        end else if (arg_hit_s) begin
            for (int i = 0; i < NumArgWords; i++) begin
                if (arg_off_s == RegAddrWidth'(i)) begin
                    rd_mux_s = arg_q[i];
                end else begin
                    rd_mux_s = rd_mux_s;
                end
            end
        end else begin
            rd_mux_s = 32'h0000_0000;
        end
    end
`else
    assign irq = 1'b0;

    // Read data mux: CTRL and argument words only
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        if (ctrl_hit_s) begin
            rd_mux_s = ctrl_val_s;
        end else if (arg_hit_s) begin
            for (int i = 0; i < NumArgWords; i++) begin
                if (arg_off_s == RegAddrWidth'(i)) begin
                    rd_mux_s = arg_q[i];
                end else begin
                    rd_mux_s = rd_mux_s;
                end
            end
        end else begin
            rd_mux_s = 32'h0000_0000;
        end
    end
`endif

    assign kernelGo = go_q;

    // FSM, DONE, start pulse and argument word registers
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            go_q    <= 1'b0;
            for (int i = 0; i < NumArgWords; i++) begin
                arg_q[i] <= 32'h0000_0000;
            end
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            go_q    <= go_d;
            for (int i = 0; i < NumArgWords; i++) begin
                arg_q[i] <= arg_d[i];
            end
        end
    end

endmodule

// File: tb/tb_sda_kernel_ctrl_args.sv
// Directed self-checking bench for sda_kernel_ctrl_args (default parameters).
module tb_sda_kernel_ctrl_args;

    logic         clk = 1'b0;
    logic         srst;
    logic         regReq;
    logic         regAck;
    logic         regWriteEn;
    logic [11:0]  regAddr;
    logic [31:0]  regWData;
    logic [3:0]   regWStrb;
    logic [31:0]  regRData;
    logic [511:0] argData;
    logic         kernelGo;
    logic         kernelDone;
    logic         irq;

    int checks   = 0;
    int failures = 0;
    int go_cnt   = 0;
    logic [31:0] rd;

    localparam logic [11:0] A_CTRL = 12'd0;
    localparam logic [11:0] A_IER  = 12'd1;
    localparam logic [11:0] A_ISR  = 12'd2;
    localparam logic [11:0] A_ARG0 = 12'd64;

    sda_kernel_ctrl_args dut (
        .clk        (clk),
        .srst       (srst),
        .regReq     (regReq),
        .regAck     (regAck),
        .regWriteEn (regWriteEn),
        .regAddr    (regAddr),
        .regWData   (regWData),
        .regWStrb   (regWStrb),
        .regRData   (regRData),
        .argData    (argData),
        .kernelGo   (kernelGo),
        .kernelDone (kernelDone),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (kernelGo) go_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One bus transaction; optionally pulses kernelDone in the decode cycle
    task automatic bus_xfer(input logic we, input logic [11:0] a, input logic [31:0] wd,
                            input logic [3:0] st, input logic kd, output logic [31:0] d);
        logic got;
        got = 1'b0;
        d   = 32'h0;
        @(negedge clk);
        regReq = 1'b1; regWriteEn = we; regAddr = a; regWData = wd; regWStrb = st;
        kernelDone = kd;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            kernelDone = 1'b0;
            if (regAck) begin
                got = 1'b1;
                d   = regRData;
            end
        end
        chk("ack_seen", {63'd0, got}, 64'd1);
        @(posedge clk); #1;
        chk("ack_one_cycle", {63'd0, regAck}, 64'd0);
        @(negedge clk);
        regReq = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_done();
        @(negedge clk); kernelDone = 1'b1;
        @(negedge clk); kernelDone = 1'b0;
    endtask

    initial begin
        srst = 1'b1; regReq = 1'b0; regWriteEn = 1'b0; regAddr = 12'd0;
        regWData = 32'd0; regWStrb = 4'd0; kernelDone = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {63'd0, regAck}, 64'd0);
        chk("rst_rdata", {32'd0, regRData}, 64'd0);
        chk("rst_args_zero", {63'd0, (argData == 512'd0)}, 64'd1);
        chk("rst_go", {63'd0, kernelGo}, 64'd0);
        chk("rst_irq", {63'd0, irq}, 64'd0);
        @(negedge clk); srst = 1'b0;

        bus_xfer(1'b0, A_CTRL, 32'h0, 4'h0, 1'b0, rd);
        chk("ctrl_reset", {32'd0, rd}, 64'h4);

        // Byte-strobed argument write
        bus_xfer(1'b1, A_ARG0 + 12'd3, 32'hA5A5_A5A5, 4'b0101, 1'b0, rd);
        chk("arg3_bus", {32'd0, argData[127:96]}, 64'h00A5_00A5);
        bus_xfer(1'b0, A_ARG0 + 12'd3, 32'h0, 4'h0, 1'b0, rd);
        chk("arg3_read", {32'd0, rd}, 64'h00A5_00A5);
        chk("arg_write_rdata_zero", {32'd0, regRData}, 64'd0);

        // Launch; writes in RUN are dropped
        bus_xfer(1'b1, A_CTRL, 32'h1, 4'h1, 1'b0, rd);
        chk("go_once", go_cnt, 64'd1);
        bus_xfer(1'b0, A_CTRL, 32'h0, 4'h0, 1'b0, rd);
        chk("ctrl_run", {32'd0, rd}, 64'h1);
        bus_xfer(1'b1, A_ARG0, 32'hFFFF_FFFF, 4'hF, 1'b0, rd);
        chk("arg0_protected", {32'd0, argData[31:0]}, 64'd0);
        bus_xfer(1'b1, A_CTRL, 32'h1, 4'h1, 1'b0, rd);
        chk("start_in_run_ignored", go_cnt, 64'd1);

        // Completion and sticky DONE
        pulse_done();
        bus_xfer(1'b0, A_CTRL, 32'h0, 4'h0, 1'b0, rd);
        chk("ctrl_done", {32'd0, rd}, 64'h6);
        bus_xfer(1'b0, A_CTRL, 32'h0, 4'h0, 1'b0, rd);
        chk("ctrl_done_cleared", {32'd0, rd}, 64'h4);

        // kernelDone coincident with a start write in RUN
        bus_xfer(1'b1, A_CTRL, 32'h1, 4'h1, 1'b0, rd);
        chk("go_second", go_cnt, 64'd2);
        bus_xfer(1'b1, A_CTRL, 32'h1, 4'h1, 1'b1, rd);
        chk("coincident_no_go", go_cnt, 64'd2);
        bus_xfer(1'b0, A_CTRL, 32'h0, 4'h0, 1'b0, rd);
        chk("coincident_ctrl", {32'd0, rd}, 64'h6);

        // kernelDone coincident with a CTRL read
        bus_xfer(1'b1, A_CTRL, 32'h1, 4'h1, 1'b0, rd);
        chk("go_third", go_cnt, 64'd3);
        bus_xfer(1'b0, A_CTRL, 32'h0, 4'h0, 1'b1, rd);
        chk("read_pre_update", {32'd0, rd}, 64'h1);
        bus_xfer(1'b0, A_CTRL, 32'h0, 4'h0, 1'b0, rd);
        chk("done_kept", {32'd0, rd}, 64'h6);

        // kernelDone in IDLE ignored; strobe 0 on CTRL ignored
        pulse_done();
        bus_xfer(1'b0, A_CTRL, 32'h0, 4'h0, 1'b0, rd);
        chk("done_in_idle", {32'd0, rd}, 64'h4);
        bus_xfer(1'b1, A_CTRL, 32'h1, 4'hE, 1'b0, rd);
        chk("ctrl_strb0_needed", go_cnt, 64'd3);

        // Unmapped and last argument word
        bus_xfer(1'b1, 12'h100, 32'h1234_5678, 4'hF, 1'b0, rd);
        bus_xfer(1'b0, 12'h100, 32'h0, 4'h0, 1'b0, rd);
        chk("unmapped_read", {32'd0, rd}, 64'd0);
        bus_xfer(1'b1, A_ARG0 + 12'd15, 32'hDEAD_BEEF, 4'hF, 1'b0, rd);
        chk("arg15_bus", {32'd0, argData[511:480]}, 64'hDEAD_BEEF);
        bus_xfer(1'b1, A_ARG0 + 12'd16, 32'h1111_1111, 4'hF, 1'b0, rd);
        chk("args_after_oob", {63'd0, (argData[479:128] == 352'd0 && argData[95:0] == 96'd0)}, 64'd1);

`ifdef KERNEL_IRQ_EN
        bus_xfer(1'b1, A_IER, 32'h1, 4'h1, 1'b0, rd);
        bus_xfer(1'b0, A_IER, 32'h0, 4'h0, 1'b0, rd);
        chk("ier_read", {32'd0, rd}, 64'h1);
        bus_xfer(1'b1, A_CTRL, 32'h1, 4'h1, 1'b0, rd);
        @(negedge clk); kernelDone = 1'b1;
        @(posedge clk); #1; kernelDone = 1'b0;
        chk("irq_not_yet", {63'd0, irq}, 64'd0);
        @(posedge clk); #1;
        chk("irq_set", {63'd0, irq}, 64'd1);
        bus_xfer(1'b1, A_ISR, 32'h1, 4'h1, 1'b0, rd);
        chk("irq_cleared", {63'd0, irq}, 64'd0);
`else
        bus_xfer(1'b0, A_IER, 32'h0, 4'h0, 1'b0, rd);
        chk("ier_unmapped", {32'd0, rd}, 64'd0);
        bus_xfer(1'b1, A_CTRL, 32'h1, 4'h1, 1'b0, rd);
        pulse_done();
        bus_xfer(1'b0, A_ISR, 32'h0, 4'h0, 1'b0, rd);
        chk("isr_unmapped", {32'd0, rd}, 64'd0);
        chk("irq_tied", {63'd0, irq}, 64'd0);
`endif

        // Reset while running
        bus_xfer(1'b1, A_ARG0 + 12'd5, 32'h0BAD_F00D, 4'hF, 1'b0, rd);
        bus_xfer(1'b1, A_CTRL, 32'h1, 4'h1, 1'b0, rd);
        chk("go_before_srst", go_cnt, 64'd5);
        @(negedge clk); srst = 1'b1;
        @(negedge clk); srst = 1'b0;
        chk("srst_args_zero", {63'd0, (argData == 512'd0)}, 64'd1);
        bus_xfer(1'b0, A_CTRL, 32'h0, 4'h0, 1'b0, rd);
        chk("srst_ctrl_idle", {32'd0, rd}, 64'h4);
        chk("srst_no_go", go_cnt, 64'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
